mem_stage_controller: RTL and testbench
=======================================

Name: mem_stage_controller

Overview:
Sequences data-memory accesses in the MEM stage of the 5-stage pipeline. It drives a variable-latency data-memory request/ready handshake and stalls the upstream pipeline (PC, IF/ID, ID/EX, EX/MEM) while an access is outstanding. It controls capture into the MEM/WB register, inserting bubbles (reg_write forced 0) during stalls and faults. It also detects misaligned or illegal accesses and memory timeouts, and keeps a saturating stall-cycle counter.

Parameters:
TIMEOUT, 64, max WAIT-state cycles before a bus error (1..255)
CNT_W, 16, width of stall_cycles counter

Ports:
clk  in  1  clock
rst  in  1  reset
mem_read  in  1  EX/MEM load request
mem_write  in  1  EX/MEM store request
addr  in  32  EX/MEM ALU result (byte address)
wdata  in  32  store data
dmem_ready  in  1  memory completes access this cycle
err_clear  in  1  one-cycle pulse, exits ERROR
dmem_req  out  1  access request
dmem_we  out  1  1 = write
dmem_addr  out  32  word-aligned address
dmem_wdata  out  32  store data
stall  out  1  freeze PC and IF/ID, ID/EX, EX/MEM registers
mw_enable  out  1  MEM/WB capture enable
mw_bubble  out  1  MEM/WB captures reg_write=0, mem_reg=0
access_fault  out  1  one-cycle pulse: misaligned or read+write
bus_error  out  1  sticky timeout flag
stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset: rst is asynchronous, active-high. It forces state=IDLE, wait_cnt=0, bus_error=0, stall_cycles=0. All outputs are 0 while rst is high, except mw_enable=1.
- Definitions:
  - access = mem_read | mem_write.
  - fault = access & ((addr[1:0] != 0) | (mem_read & mem_write)).
  - good = access & !fault.
- dmem_addr = {addr[31:2], 2'b00}, dmem_wdata = wdata, dmem_we = mem_write & dmem_req. These are combinational from EX/MEM; they stay stable because EX/MEM is stalled.
- mw_enable = 1 in every state. MEM/WB always clocks; stalls are converted to bubbles.
- IDLE:
  - no access: dmem_req=0, stall=0, mw_bubble=0.
  - good: dmem_req=1 the same cycle.
    - dmem_ready=1: access completes with zero wait. stall=0, mw_bubble=0, stay IDLE.
    - dmem_ready=0: stall=1, mw_bubble=1, next state WAIT, wait_cnt=1.
  - fault: dmem_req=0, access_fault=1 for one cycle, mw_bubble=1, stall=0. The instruction is squashed and the state stays IDLE.
- WAIT:
  - dmem_req=1.
  - dmem_ready=1: completes. stall=0, mw_bubble=0, next state IDLE, wait_cnt=0.
  - dmem_ready=0 and wait_cnt < TIMEOUT: stall=1, mw_bubble=1, wait_cnt++.
  - dmem_ready=0 and wait_cnt == TIMEOUT: stall=1, mw_bubble=1, next state ERROR, bus_error set on that edge.
- ERROR:
  - dmem_req=0, stall=1, mw_bubble=1, bus_error=1.
  - err_clear=1: next state IDLE, bus_error cleared, stall=0 and mw_bubble=1 that cycle. The faulting access is dropped and never reissued.
  - dmem_ready is ignored in ERROR.
- Simultaneous events:
  - dmem_ready=1 on the same cycle wait_cnt reaches TIMEOUT: completion wins, no error.
  - err_clear outside ERROR: ignored.
- stall_cycles increments on every clock edge where stall=1, saturating at all-ones with no wrap.
- Reset mid-access (WAIT/ERROR) drops dmem_req immediately (asynchronously). The pending access is abandoned.
- Each memory request completes exactly once; dmem_req never deasserts in WAIT before ready or timeout.

Test Plan:
- Zero-wait load: mem_read=1, addr=0x100, dmem_ready=1 same cycle -> dmem_req high 1 cycle, dmem_we=0, stall=0, mw_bubble=0, stall_cycles=0.
- 3-wait store: mem_write=1, addr=0x204, wdata=0xDEADBEEF, ready low 3 cycles then high -> dmem_req high 4 cycles with dmem_we=1, stall/mw_bubble high 3 cycles, stall_cycles=3, back to IDLE.
- Timeout (TIMEOUT=8): load with ready held 0 -> 8 stalled WAIT cycles, then ERROR with bus_error=1, dmem_req=0, stall held. An err_clear pulse then gives bus_error=0, stall=0, and no reissued request.
- Faults: load addr=0x102 -> access_fault 1-cycle pulse, dmem_req=0, mw_bubble=1, stall=0. mem_read=mem_write=1 at addr=0x100 -> same response.
- Reset mid-WAIT: assert rst asynchronously 2 cycles into WAIT -> dmem_req and stall drop before the next edge, stall_cycles=0. After release, the next load behaves as the zero-wait case.
- Saturation (CNT_W=4): 20 stalled cycles -> stall_cycles=0xF and holds.

Source files
------------

// File: rtl/mem_stage_if.sv
// MEM-stage bundle: EX/MEM request side, data-memory handshake and pipeline control outputs.
// The controller takes the master modport. The pipeline/memory model takes the slave modport.
interface mem_stage_if #(
    parameter int CNT_W = 16
);
    logic             mem_read;
    logic             mem_write;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic             dmem_ready;
    logic             err_clear;
    logic             dmem_req;
    logic             dmem_we;
    logic [31:0]      dmem_addr;
    logic [31:0]      dmem_wdata;
    logic             stall;
    logic             mw_enable;
    logic             mw_bubble;
    logic             access_fault;
    logic             bus_error;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        input  mem_read, mem_write, addr, wdata, dmem_ready, err_clear,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, stall, mw_enable,
        output mw_bubble, access_fault, bus_error, stall_cycles
    );

    modport slave (
        output mem_read, mem_write, addr, wdata, dmem_ready, err_clear,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, stall, mw_enable,
        input  mw_bubble, access_fault, bus_error, stall_cycles
    );
endinterface

// File: rtl/mem_stage_controller.sv
// MEM-stage data-memory sequencer: variable-latency handshake, pipeline stall/bubble control,
// access-fault and timeout detection, saturating stall-cycle counter.
module mem_stage_controller #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    mem_stage_if.master  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_ERROR = 2'd2;
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [1:0]       state_reg, state_next;
    logic [7:0]       wait_cnt_reg, wait_cnt_next;
    logic             bus_error_reg, bus_error_next;
    logic [CNT_W-1:0] stall_cycles_reg;

    logic access, fault, good;
    logic req, stall, bubble, afault;

    assign access = bus.mem_read | bus.mem_write;
    assign fault  = access & ((bus.addr[1:0] != 2'b00) | (bus.mem_read & bus.mem_write));
    assign good   = access & ~fault;

    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        bus_error_next = bus_error_reg;
        req            = 1'b0;
        stall          = 1'b0;
        bubble         = 1'b0;
        afault         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (fault) begin
                    afault = 1'b1;
                    bubble = 1'b1;
                end else if (good) begin
                    req = 1'b1;
                    if (!bus.dmem_ready) begin
                        stall         = 1'b1;
                        bubble        = 1'b1;
                        state_next    = ST_WAIT;
                        wait_cnt_next = 8'd1;
                    end
                end
            end
            ST_WAIT: begin
                req = 1'b1;
                // Completion takes priority over the timeout on the same cycle.
                if (bus.dmem_ready) begin
                    state_next    = ST_IDLE;
                    wait_cnt_next = 8'd0;
                end else begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    if (wait_cnt_reg < TIMEOUT_C) begin
                        wait_cnt_next = wait_cnt_reg + 8'd1;
                    end else begin
                        state_next     = ST_ERROR;
                        bus_error_next = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                bubble = 1'b1;
                if (bus.err_clear) begin
                    state_next     = ST_IDLE;
                    wait_cnt_next  = 8'd0;
                    bus_error_next = 1'b0;
                end else begin
                    stall = 1'b1;
                end
            end
            default: begin
                state_next    = ST_IDLE;
                wait_cnt_next = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            wait_cnt_reg     <= 8'd0;
            bus_error_reg    <= 1'b0;
            stall_cycles_reg <= '0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            bus_error_reg <= bus_error_next;
            if (stall && (stall_cycles_reg != '1)) begin
                stall_cycles_reg <= stall_cycles_reg + 1'b1;
            end
        end
    end

    // Reset gates the combinational outputs so a mid-access reset drops the request at once.
    assign bus.dmem_req     = req & ~rst;
    assign bus.dmem_we      = bus.mem_write & req & ~rst;
    assign bus.dmem_addr    = rst ? 32'd0 : {bus.addr[31:2], 2'b00};
    assign bus.dmem_wdata   = rst ? 32'd0 : bus.wdata;
    assign bus.stall        = stall & ~rst;
    assign bus.mw_enable    = 1'b1;
    assign bus.mw_bubble    = bubble & ~rst;
    assign bus.access_fault = afault & ~rst;
    assign bus.bus_error    = bus_error_reg;
    assign bus.stall_cycles = stall_cycles_reg;
endmodule

// File: tb/tb_mem_stage_controller.sv
// Directed bench for mem_stage_controller (TIMEOUT=8, CNT_W=4): zero-wait, multi-wait,
// faults, timeout/clear, completion-at-timeout, async reset mid-WAIT and counter saturation.
module tb_mem_stage_controller;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_stage_if #(.CNT_W(CNT_W)) bus ();

    mem_stage_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic rdy, input logic clr);
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.addr       = a;
        bus.wdata      = d;
        bus.dmem_ready = rdy;
        bus.err_clear  = clr;
        #2;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;

        // Reset: outputs held low (mw_enable high) even with a request presented.
        drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0);
        chk("rst_req", bus.dmem_req, 1'b0);
        chk("rst_addr", bus.dmem_addr, 32'h0);
        chk("rst_stall", bus.stall, 1'b0);
        chk("rst_mwen", bus.mw_enable, 1'b1);
        chk("rst_bubble", bus.mw_bubble, 1'b0);
        chk("rst_berr", bus.bus_error, 1'b0);
        chk("rst_cnt", bus.stall_cycles, 4'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;

        // Zero-wait load
        drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0);
        chk("zw_req", bus.dmem_req, 1'b1);
        chk("zw_we", bus.dmem_we, 1'b0);
        chk("zw_addr", bus.dmem_addr, 32'h100);
        chk("zw_stall", bus.stall, 1'b0);
        chk("zw_bubble", bus.mw_bubble, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("zw_req_off", bus.dmem_req, 1'b0);
        chk("zw_cnt", bus.stall_cycles, 4'h0);

        // 3-wait store
        drive(1'b0, 1'b1, 32'h204, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("st_req0", bus.dmem_req, 1'b1);
        chk("st_we0", bus.dmem_we, 1'b1);
        chk("st_wdata", bus.dmem_wdata, 32'hDEADBEEF);
        chk("st_addr", bus.dmem_addr, 32'h204);
        chk("st_stall0", bus.stall, 1'b1);
        chk("st_bubble0", bus.mw_bubble, 1'b1);
        for (int i = 1; i <= 2; i++) begin
            tick();
            #2;
            chk("st_req_w", bus.dmem_req, 1'b1);
            chk("st_we_w", bus.dmem_we, 1'b1);
            chk("st_stall_w", bus.stall, 1'b1);
        end
        tick();
        drive(1'b0, 1'b1, 32'h204, 32'hDEADBEEF, 1'b1, 1'b0);
        chk("st_req_done", bus.dmem_req, 1'b1);
        chk("st_stall_done", bus.stall, 1'b0);
        chk("st_bubble_done", bus.mw_bubble, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("st_req_off", bus.dmem_req, 1'b0);
        chk("st_cnt", bus.stall_cycles, 4'h3);

        // Faults: misaligned load, then read+write together
        drive(1'b1, 1'b0, 32'h102, 32'h0, 1'b1, 1'b0);
        chk("mis_fault", bus.access_fault, 1'b1);
        chk("mis_req", bus.dmem_req, 1'b0);
        chk("mis_bubble", bus.mw_bubble, 1'b1);
        chk("mis_stall", bus.stall, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("mis_fault_off", bus.access_fault, 1'b0);
        drive(1'b1, 1'b1, 32'h100, 32'h0, 1'b1, 1'b0);
        chk("rw_fault", bus.access_fault, 1'b1);
        chk("rw_req", bus.dmem_req, 1'b0);
        chk("rw_we", bus.dmem_we, 1'b0);
        chk("rw_bubble", bus.mw_bubble, 1'b1);
        chk("rw_stall", bus.stall, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("rw_cnt", bus.stall_cycles, 4'h3);

        // Timeout: one IDLE stall plus 8 WAIT stalls, then ERROR
        drive(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i <= TIMEOUT; i++) begin
            chk("to_req", bus.dmem_req, 1'b1);
            chk("to_stall", bus.stall, 1'b1);
            chk("to_berr_pre", bus.bus_error, 1'b0);
            tick();
            #2;
        end
        chk("err_req", bus.dmem_req, 1'b0);
        chk("err_stall", bus.stall, 1'b1);
        chk("err_bubble", bus.mw_bubble, 1'b1);
        chk("err_berr", bus.bus_error, 1'b1);
        chk("err_cnt", bus.stall_cycles, 4'hC);
        // dmem_ready is ignored while in ERROR
        drive(1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 1'b0);
        chk("err_rdy_req", bus.dmem_req, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0);
        chk("err_rdy_berr", bus.bus_error, 1'b1);
        chk("err_rdy_stall", bus.stall, 1'b1);
        chk("err_cnt13", bus.stall_cycles, 4'hD);
        // Saturation: keep stalling in ERROR well past 15
        for (int i = 0; i < 7; i++) tick();
        chk("sat_cnt", bus.stall_cycles, 4'hF);
        tick();
        chk("sat_hold", bus.stall_cycles, 4'hF);

        // err_clear: leave ERROR, no reissue
        drive(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b1);
        chk("clr_stall", bus.stall, 1'b0);
        chk("clr_bubble", bus.mw_bubble, 1'b1);
        chk("clr_req", bus.dmem_req, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("clr_berr", bus.bus_error, 1'b0);
        chk("clr_req_after", bus.dmem_req, 1'b0);
        chk("clr_stall_after", bus.stall, 1'b0);
        // err_clear outside ERROR has no effect
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("clr_idle_stall", bus.stall, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Completion on the same cycle wait_cnt reaches TIMEOUT wins
        drive(1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT; i++) tick();
        drive(1'b1, 1'b0, 32'h400, 32'h0, 1'b1, 1'b0);
        chk("race_req", bus.dmem_req, 1'b1);
        chk("race_stall", bus.stall, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("race_berr", bus.bus_error, 1'b0);
        chk("race_req_off", bus.dmem_req, 1'b0);

        // Reset mid-WAIT: outputs drop before the next edge
        drive(1'b1, 1'b0, 32'h500, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        #1;
        chk("mw_req_pre", bus.dmem_req, 1'b1);
        rst = 1'b1;
        #1;
        chk("mw_req_rst", bus.dmem_req, 1'b0);
        chk("mw_stall_rst", bus.stall, 1'b0);
        chk("mw_cnt_rst", bus.stall_cycles, 4'h0);
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0);
        chk("post_req", bus.dmem_req, 1'b1);
        chk("post_stall", bus.stall, 1'b0);
        chk("post_bubble", bus.mw_bubble, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("post_cnt", bus.stall_cycles, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
